// File: rtl/bird_pkg.sv
// Shared types and default constants for the bird motion controller.
package bird_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RISE,
        FALL,
        DEAD
    } motion_state_t;

    localparam int HEIGHT_W           = 4;
    localparam int CNT_W              = 4;
    localparam int DEFAULT_TOP        = 15;
    localparam int DEFAULT_FLOOR      = 0;
    localparam int DEFAULT_RISE_TICKS = 3;
    localparam int DEFAULT_FALL_DIV   = 2;

endpackage

// File: rtl/edge_det.sv
// Rising-edge detector for the flap level. The history register resets
// high so that a level already high when reset releases is not an edge.
module edge_det (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic in_q;

    // Remember last cycle's level; reset to 1 to suppress a spurious edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            in_q <= 1'b1;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

// File: rtl/bird_motion_ctrl.sv
// Bird motion sequencer: turns flap edges and game ticks into single-cycle
// incr/decr pulses for the height counter, clamps at the ceiling and raises
// a sticky crash flag when a fall step is requested at the floor.
module bird_motion_ctrl #(
    parameter int HEIGHT_W   = bird_pkg::HEIGHT_W,
    parameter int TOP        = bird_pkg::DEFAULT_TOP,
    parameter int FLOOR      = bird_pkg::DEFAULT_FLOOR,
    parameter int RISE_TICKS = bird_pkg::DEFAULT_RISE_TICKS,
    parameter int FALL_DIV   = bird_pkg::DEFAULT_FALL_DIV
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flap,
    input  logic                tick,
    input  logic [HEIGHT_W-1:0] height,
    output logic                incr,
    output logic                decr,
    output logic                crash,
    output logic                rising
);

    import bird_pkg::*;

    localparam logic [HEIGHT_W-1:0] TOP_H      = HEIGHT_W'(TOP);
    localparam logic [HEIGHT_W-1:0] FLOOR_H    = HEIGHT_W'(FLOOR);
    localparam logic [CNT_W-1:0]    RISE_LOAD  = CNT_W'(RISE_TICKS);
    localparam logic [CNT_W-1:0]    FALL_LAST  = CNT_W'(FALL_DIV - 1);
    localparam logic [CNT_W-1:0]    CNT_ONE    = CNT_W'(1);

    motion_state_t    state;
    logic [CNT_W-1:0] rise_cnt;
    logic [CNT_W-1:0] fall_cnt;
    logic             flap_edge;

    edge_det u_flap_edge (
        .clk   (clk),
        .reset (reset),
        .in    (flap),
        .rise  (flap_edge)
    );

    // Motion FSM with its counters and registered pulse/status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            incr     <= 1'b0;
            decr     <= 1'b0;
            crash    <= 1'b0;
            rising   <= 1'b0;
            rise_cnt <= '0;
            fall_cnt <= '0;
        end else begin
            incr <= 1'b0;
            decr <= 1'b0;
            case (state)
                IDLE: begin
                    if (flap_edge) begin
                        state    <= RISE;
                        rising   <= 1'b1;
                        rise_cnt <= RISE_LOAD;
                        fall_cnt <= '0;
                    end
                end
                RISE: begin
                    if (flap_edge) begin
                        rise_cnt <= RISE_LOAD;
                        fall_cnt <= '0;
                    end else if (tick) begin
                        incr     <= (height != TOP_H);
                        rise_cnt <= rise_cnt - CNT_ONE;
                        if (rise_cnt == CNT_ONE) begin
                            state    <= FALL;
                            rising   <= 1'b0;
                            fall_cnt <= '0;
                        end
                    end
                end
                FALL: begin
                    if (flap_edge) begin
                        state    <= RISE;
                        rising   <= 1'b1;
                        rise_cnt <= RISE_LOAD;
                        fall_cnt <= '0;
                    end else if (tick) begin
                        if (fall_cnt == FALL_LAST) begin
                            fall_cnt <= '0;
                            if (height == FLOOR_H) begin
                                state <= DEAD;
                                crash <= 1'b1;
                            end else begin
                                decr <= 1'b1;
                            end
                        end else begin
                            fall_cnt <= fall_cnt + CNT_ONE;
                        end
                    end
                end
                DEAD: begin
                    crash  <= 1'b1;
                    rising <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    rising <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bird_motion_ctrl.sv
// Testbench for bird_motion_ctrl: a bench-side height counter is fed back
// into the DUT, a cycle table covers the basic rise/fall sequence, and
// hand-written sequences cover clamping, crash, flap/tick collision and
// flap held across reset.
module tb_bird_motion_ctrl;

    logic       clk;
    logic       reset;
    logic       flap;
    logic       tick;
    logic [3:0] height;
    logic       incr;
    logic       decr;
    logic       crash;
    logic       rising;
    logic       load;
    logic [3:0] load_val;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        logic       f;
        logic       t;
        logic       ei;
        logic       ed;
        logic       er;
        logic       ec;
        logic [3:0] eh;
    } vec_t;

    vec_t vecs[$];

    bird_motion_ctrl #(
        .HEIGHT_W   (4),
        .TOP        (15),
        .FLOOR      (0),
        .RISE_TICKS (3),
        .FALL_DIV   (2)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .flap   (flap),
        .tick   (tick),
        .height (height),
        .incr   (incr),
        .decr   (decr),
        .crash  (crash),
        .rising (rising)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Height counter model driven by the DUT pulses, with a preload hook.
    always @(posedge clk) begin
        if (reset)
            height <= 4'd8;
        else if (load)
            height <= load_val;
        else if (incr)
            height <= height + 4'd1;
        else if (decr)
            height <= height - 4'd1;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic checkAll(input string tag, input logic ei, input logic ed,
                            input logic er, input logic ec, input logic [3:0] eh);
        checkOutput($sformatf("%s incr", tag),   {7'd0, incr},   {7'd0, ei});
        checkOutput($sformatf("%s decr", tag),   {7'd0, decr},   {7'd0, ed});
        checkOutput($sformatf("%s rising", tag), {7'd0, rising}, {7'd0, er});
        checkOutput($sformatf("%s crash", tag),  {7'd0, crash},  {7'd0, ec});
        checkOutput($sformatf("%s height", tag), {4'd0, height}, {4'd0, eh});
    endtask

    task automatic applyStimulus(input logic f, input logic t);
        @(negedge clk);
        flap = f;
        tick = t;
        load = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic loadHeight(input logic f, input logic [3:0] h);
        @(negedge clk);
        flap     = f;
        tick     = 1'b0;
        load     = 1'b1;
        load_val = h;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    task automatic doReset(input logic f);
        @(negedge clk);
        reset = 1'b1;
        flap  = f;
        tick  = 1'b0;
        load  = 1'b0;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idleCycles(input logic f, input int n);
        for (int k = 0; k < n; k++)
            applyStimulus(f, 1'b0);
    endtask

    task automatic addRow(input logic f, input logic t, input logic ei, input logic ed,
                          input logic er, input logic ec, input logic [3:0] eh);
        vec_t v;
        v.f = f; v.t = t; v.ei = ei; v.ed = ed; v.er = er; v.ec = ec; v.eh = eh;
        vecs.push_back(v);
    endtask

    initial begin
        reset    = 1'b0;
        flap     = 1'b0;
        tick     = 1'b0;
        load     = 1'b0;
        load_val = 4'd0;

        // ---------------- reset state and idle ticks ----------------
        doReset(1'b0);
        checkAll("reset", 0, 0, 0, 0, 4'd8);
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b0, (i % 4) == 0);
            checkAll($sformatf("idle[%0d]", i), 0, 0, 0, 0, 4'd8);
        end

        // ---------------- flap, rise 3 ticks, fall 4 ticks ----------------
        //     f  t  incr decr rise crash height
        addRow(1, 0, 0, 0, 1, 0, 4'd8);   // flap edge -> RISE
        addRow(1, 1, 1, 0, 1, 0, 4'd8);   // tick 1
        addRow(0, 0, 0, 0, 1, 0, 4'd9);
        addRow(0, 0, 0, 0, 1, 0, 4'd9);
        addRow(0, 0, 0, 0, 1, 0, 4'd9);
        addRow(0, 1, 1, 0, 1, 0, 4'd9);   // tick 2
        addRow(0, 0, 0, 0, 1, 0, 4'd10);
        addRow(0, 0, 0, 0, 1, 0, 4'd10);
        addRow(0, 0, 0, 0, 1, 0, 4'd10);
        addRow(0, 1, 1, 0, 0, 0, 4'd10);  // tick 3 -> FALL
        addRow(0, 0, 0, 0, 0, 0, 4'd11);
        addRow(0, 0, 0, 0, 0, 0, 4'd11);
        addRow(0, 0, 0, 0, 0, 0, 4'd11);
        addRow(0, 1, 0, 0, 0, 0, 4'd11);  // fall tick 1
        addRow(0, 0, 0, 0, 0, 0, 4'd11);
        addRow(0, 0, 0, 0, 0, 0, 4'd11);
        addRow(0, 0, 0, 0, 0, 0, 4'd11);
        addRow(0, 1, 0, 1, 0, 0, 4'd11);  // fall tick 2 -> decr
        addRow(0, 0, 0, 0, 0, 0, 4'd10);
        addRow(0, 0, 0, 0, 0, 0, 4'd10);
        addRow(0, 0, 0, 0, 0, 0, 4'd10);
        addRow(0, 1, 0, 0, 0, 0, 4'd10);  // fall tick 3
        addRow(0, 0, 0, 0, 0, 0, 4'd10);
        addRow(0, 0, 0, 0, 0, 0, 4'd10);
        addRow(0, 0, 0, 0, 0, 0, 4'd10);
        addRow(0, 1, 0, 1, 0, 0, 4'd10);  // fall tick 4 -> decr
        addRow(0, 0, 0, 0, 0, 0, 4'd9);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].f, vecs[i].t);
            checkAll($sformatf("vec[%0d]", i), vecs[i].ei, vecs[i].ed,
                     vecs[i].er, vecs[i].ec, vecs[i].eh);
        end

        // ---------------- ceiling clamp ----------------
        doReset(1'b0);
        checkAll("clamp reset", 0, 0, 0, 0, 4'd8);
        loadHeight(1'b0, 4'd14);
        checkAll("clamp load", 0, 0, 0, 0, 4'd14);
        applyStimulus(1'b1, 1'b0);
        checkAll("clamp flap", 0, 0, 1, 0, 4'd14);
        applyStimulus(1'b1, 1'b1);
        checkAll("clamp tick1", 1, 0, 1, 0, 4'd14);
        applyStimulus(1'b1, 1'b0);
        checkAll("clamp top", 0, 0, 1, 0, 4'd15);
        idleCycles(1'b1, 2);
        applyStimulus(1'b1, 1'b1);
        checkAll("clamp tick2", 0, 0, 1, 0, 4'd15);
        idleCycles(1'b1, 3);
        checkAll("clamp hold", 0, 0, 1, 0, 4'd15);
        applyStimulus(1'b1, 1'b1);
        checkAll("clamp tick3", 0, 0, 0, 0, 4'd15);

        // ---------------- descend to floor and crash ----------------
        loadHeight(1'b1, 4'd1);
        checkAll("crash load", 0, 0, 0, 0, 4'd1);
        applyStimulus(1'b1, 1'b1);
        checkAll("crash ftick1", 0, 0, 0, 0, 4'd1);
        idleCycles(1'b1, 3);
        applyStimulus(1'b1, 1'b1);
        checkAll("crash ftick2", 0, 1, 0, 0, 4'd1);
        applyStimulus(1'b1, 1'b0);
        checkAll("crash floor", 0, 0, 0, 0, 4'd0);
        idleCycles(1'b1, 2);
        applyStimulus(1'b1, 1'b1);
        checkAll("crash ftick3", 0, 0, 0, 0, 4'd0);
        idleCycles(1'b1, 3);
        applyStimulus(1'b1, 1'b1);
        checkAll("crash dead", 0, 0, 0, 1, 4'd0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus((i % 2) == 0, (i % 4) == 1);
            checkAll($sformatf("dead[%0d]", i), 0, 0, 0, 1, 4'd0);
        end
        doReset(1'b0);
        checkAll("dead reset", 0, 0, 0, 0, 4'd8);
        applyStimulus(1'b0, 1'b1);
        checkAll("post-dead idle tick", 0, 0, 0, 0, 4'd8);

        // ---------------- flap coincident with tick in FALL ----------------
        doReset(1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0);
        checkAll("coin flap", 0, 0, 1, 0, 4'd8);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkAll($sformatf("coin rise%0d", i), 1, 0, (i != 2), 0, 4'(8 + i));
            idleCycles(1'b1, 3);
        end
        checkAll("coin top of rise", 0, 0, 0, 0, 4'd11);
        applyStimulus(1'b1, 1'b1);
        checkAll("coin fall_cnt1", 0, 0, 0, 0, 4'd11);
        idleCycles(1'b1, 2);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1);
        checkAll("coin flap+tick", 0, 0, 1, 0, 4'd11);
        idleCycles(1'b1, 3);
        checkAll("coin settle", 0, 0, 1, 0, 4'd11);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b1);
            checkAll($sformatf("coin rerise%0d", i), 1, 0, (i != 2), 0, 4'(11 + i));
            idleCycles(1'b1, 3);
        end
        checkAll("coin end", 0, 0, 0, 0, 4'd14);

        // ---------------- flap held across reset release ----------------
        doReset(1'b1);
        checkAll("held reset", 0, 0, 0, 0, 4'd8);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, (i % 4) == 0);
            checkAll($sformatf("held[%0d]", i), 0, 0, 0, 0, 4'd8);
        end
        applyStimulus(1'b0, 1'b0);
        checkAll("held drop", 0, 0, 0, 0, 4'd8);
        applyStimulus(1'b1, 1'b0);
        checkAll("held reflap", 0, 0, 1, 0, 4'd8);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
